// File: rtl/bf_uart_pkg.sv
// Shared types and helpers for the verifuck UART receive path.
// Optional build macro: UART_RX_PARITY_EN (8E1 framing instead of 8N1).
package bf_uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam int DATA_BITS = 8;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/bf_rx_fifo.sv
// Small synchronous receive FIFO, 8 bits wide. A push while full is accepted
// only when a pop happens in the same cycle (the head slot is being freed).
module bf_rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] din,
  output logic       full,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bf_uart_rx.sv
// UART receiver for the CPU ',' instruction: pin synchroniser, frame FSM and
// receive FIFO. Define UART_RX_PARITY_EN for 8E1 framing (default is 8N1).
module bf_uart_rx
  import bf_uart_pkg::*;
#(
  parameter int CLK_HZ     = 12000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx_pin,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_overrun,
  output logic       rx_frame_err,
  output rx_state_t  dbg_state
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS - 1);

  logic             sync1, rxs, rxs_d;
  logic [1:0]       flush;
  logic             armed;
  logic             start_det;
  rx_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       idx, idx_nxt;
  logic [7:0]       shreg, shreg_nxt;
  logic             push;
  logic             ferr_nxt;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
`ifdef UART_RX_PARITY_EN
  logic             par_err, par_err_nxt;
`endif

  // The synchroniser resets to 1, so arming waits until flush shows that rxs
  // holds a real pin sample; a line stuck low across reset never arms.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
      rxs_d <= 1'b1;
      flush <= 2'b00;
      armed <= 1'b0;
    end else begin
      sync1 <= uart_rx_pin;
      rxs   <= sync1;
      rxs_d <= rxs;
      flush <= {flush[0], 1'b1};
      armed <= armed | (flush[1] & rxs);
    end
  end

  assign start_det = armed && rxs_d && !rxs;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = (cnt == '0) ? cnt : cnt - 1'b1;
    idx_nxt   = idx;
    shreg_nxt = shreg;
    push      = 1'b0;
    ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_nxt = par_err;
`endif
    case (state)
      IDLE: begin
        if (start_det) begin
          state_nxt = START;
          cnt_nxt   = CNT_HALF;
`ifdef UART_RX_PARITY_EN
          par_err_nxt = 1'b0;
`endif
        end
      end
      START: begin
        if (cnt == '0) begin
          if (!rxs) begin
            state_nxt = DATA;
            cnt_nxt   = CNT_BIT;
            idx_nxt   = '0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt == '0) begin
          shreg_nxt = {rxs, shreg[7:1]};
          cnt_nxt   = CNT_BIT;
          idx_nxt   = idx + 1'b1;
          if (idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == '0) begin
          par_err_nxt = rxs ^ (^shreg);
          cnt_nxt     = CNT_BIT;
          state_nxt   = STOP;
        end
      end
`endif
      STOP: begin
        // Return to IDLE at mid-stop so a back-to-back start edge is caught.
        if (cnt == '0) begin
          state_nxt = IDLE;
`ifdef UART_RX_PARITY_EN
          if (rxs && !par_err) push = 1'b1;
`else
          if (rxs) push = 1'b1;
`endif
          else ferr_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      idx          <= '0;
      shreg        <= '0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err      <= 1'b0;
`endif
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      idx          <= idx_nxt;
      shreg        <= shreg_nxt;
      rx_overrun   <= push && fifo_full && !pop;
      rx_frame_err <= ferr_nxt;
`ifdef UART_RX_PARITY_EN
      par_err      <= par_err_nxt;
`endif
    end
  end

  // Handshake: a byte transfers on every clk edge where rx_valid && rx_ready;
  // rx_data is held steady while rx_valid is high and rx_ready is low.
  assign pop       = rx_valid && rx_ready;
  assign rx_valid  = !fifo_empty;
  assign dbg_state = state;

  bf_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (shreg_nxt),
    .full  (fifo_full),
    .pop   (pop),
    .dout  (rx_data),
    .empty (fifo_empty)
  );

endmodule
